// File: rtl/memwb_pkg.sv
// memwb_pkg: shared constants, entry layout and occupancy states for the MEM/WB stage
// Contents: control-bit positions, default widths, default-width entry_t, occ_t.
package memwb_pkg;
    localparam int XLEN_DEF          = 64;
    localparam int RD_W_DEF          = 5;
    localparam int CTRL_W_DEF        = 2;
    localparam int CTRL_REGWRITE_BIT = 0;
    localparam int CTRL_MEMTOREG_BIT = 1;
    typedef struct packed {
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [XLEN_DEF-1:0]   alu_result;
        logic [XLEN_DEF-1:0]   read_data;
        logic [XLEN_DEF-1:0]   wb_data;
        logic [RD_W_DEF-1:0]   rd;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
endpackage

// File: rtl/memwb_pipe_stage_if.sv
// memwb_pipe_stage_if: MEM-side and WB-side handshake buses of the MEM/WB stage
// in_*  : MEM stage -> stage entry (valid/ready, ctrl, alu_result, read_data, rd)
// out_* : stage -> WB entry (valid/ready, ctrl, alu_result, read_data, wb_data, rd)
// slave  : view of the pipeline stage; master : view of the surrounding pipeline
interface memwb_pipe_stage_if
    import memwb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [XLEN-1:0]   in_alu_result;
    logic [XLEN-1:0]   in_read_data;
    logic [RD_W-1:0]   in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_alu_result;
    logic [XLEN-1:0]   out_read_data;
    logic [XLEN-1:0]   out_wb_data;
    logic [RD_W-1:0]   out_rd;
    modport slave (
        input  in_valid, in_ctrl, in_alu_result, in_read_data, in_rd, out_ready,
        output in_ready, out_valid, out_ctrl, out_alu_result, out_read_data, out_wb_data, out_rd
    );
    modport master (
        output in_valid, in_ctrl, in_alu_result, in_read_data, in_rd, out_ready,
        input  in_ready, out_valid, out_ctrl, out_alu_result, out_read_data, out_wb_data, out_rd
    );
endinterface

// File: rtl/memwb_entry_pack.sv
// memwb_entry_pack: builds the stored control vector and writeback data from MEM inputs
// in_ctrl/in_alu_result/in_read_data/in_rd : raw MEM stage fields
// ctrl    : in_ctrl with RegWrite cleared when rd is x0
// wb_data : read data when MemToReg, else ALU result
module memwb_entry_pack
    import memwb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_read_data,
    input  logic [RD_W-1:0]   in_rd,
    output logic [CTRL_W-1:0] ctrl,
    output logic [XLEN-1:0]   wb_data
);
    always_comb begin
        ctrl                    = in_ctrl;
        ctrl[CTRL_REGWRITE_BIT] = in_ctrl[CTRL_REGWRITE_BIT] & (in_rd != '0);
        wb_data                 = in_ctrl[CTRL_MEMTOREG_BIT] ? in_read_data : in_alu_result;
    end
endmodule

// File: rtl/memwb_pipe_stage.sv
// memwb_pipe_stage: MEM/WB pipeline register with valid/ready handshake and 2-entry skid buffer
// clock, reset : rising-edge clock, synchronous active-high reset
// flush        : drops both buffered entries and any simultaneous input
// bus          : memwb_pipe_stage_if.slave carrying the in_* and out_* buses
// MEMWB_PIPE_STAGE_PERF_EN adds stall_cnt / bubble_cnt saturating 32-bit counters.
module memwb_pipe_stage
    import memwb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    memwb_pipe_stage_if.slave    bus
`ifdef MEMWB_PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          bubble_cnt
`endif
);
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   read_data;
        logic [XLEN-1:0]   wb_data;
        logic [RD_W-1:0]   rd;
    } ent_t;

    occ_t              state, state_n;
    ent_t              main_q, skid_q, in_ent;
    logic [CTRL_W-1:0] pack_ctrl;
    logic [XLEN-1:0]   pack_wb;
    logic              in_ready_q, out_valid, accept, drain;

    memwb_entry_pack #(.XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_pack (
        .in_ctrl       (bus.in_ctrl),
        .in_alu_result (bus.in_alu_result),
        .in_read_data  (bus.in_read_data),
        .in_rd         (bus.in_rd),
        .ctrl          (pack_ctrl),
        .wb_data       (pack_wb)
    );

    assign in_ent    = {pack_ctrl, bus.in_alu_result, bus.in_read_data, pack_wb, bus.in_rd};
    assign out_valid = state != EMPTY;
    assign accept    = bus.in_valid & in_ready_q;
    assign drain     = out_valid & bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset) state <= EMPTY;
        else       state <= state_n;
    end

    always_comb begin
        state_n = flush          ? EMPTY :
                  state == EMPTY ? (accept ? ONE : EMPTY) :
                  state == ONE   ? ((accept && !drain) ? TWO : (!accept && drain) ? EMPTY : ONE) :
                                   (drain ? ONE : TWO);
    end

    // A flushed main entry keeps its data fields; only ctrl is cleared so WB sees no write.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            main_q.ctrl <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            if ((state == EMPTY && accept) || (state == ONE && accept && drain)) main_q <= in_ent;
            else if (state == TWO && drain)                                      main_q <= skid_q;
            if (state == ONE && accept && !drain) skid_q <= in_ent;
            in_ready_q <= state_n != TWO;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_ctrl       = main_q.ctrl;
    assign bus.out_alu_result = main_q.alu_result;
    assign bus.out_read_data  = main_q.read_data;
    assign bus.out_wb_data    = main_q.wb_data;
    assign bus.out_rd         = main_q.rd;

`ifdef MEMWB_PIPE_STAGE_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !bus.out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && bubble_cnt != '1)                 bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_memwb_pipe_stage.sv
// tb_memwb_pipe_stage: scoreboard bench for memwb_pipe_stage with directed vectors
module tb_memwb_pipe_stage;
    import memwb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    always #5 clock = ~clock;

    memwb_pipe_stage_if #(.XLEN(64), .RD_W(5), .CTRL_W(2)) bus ();
`ifdef MEMWB_PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    memwb_pipe_stage #(.XLEN(64), .RD_W(5), .CTRL_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef MEMWB_PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    entry_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int pops   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && !flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got rd 0x%0h wb 0x%0h want no entry", bus.out_rd, bus.out_wb_data);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("sb_ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
                check("sb_alu", bus.out_alu_result, e.alu_result);
                check("sb_read", bus.out_read_data, e.read_data);
                check("sb_wb", bus.out_wb_data, e.wb_data);
                check("sb_rd", 64'(bus.out_rd), 64'(e.rd));
                pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d,
                        input logic [4:0] r, input logic [1:0] ec, input logic [63:0] ew);
        int n;
        n = 0;
        bus.in_valid      = 1'b1;
        bus.in_ctrl       = c;
        bus.in_alu_result = a;
        bus.in_read_data  = d;
        bus.in_rd         = r;
        @(negedge clock);
        while (!bus.in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready 0 want 1");
        end else begin
            exp_q.push_back('{ctrl: ec, alu_result: a, read_data: d, wb_data: ew, rd: r});
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, want finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid      = 1'b0;
        bus.in_ctrl       = '0;
        bus.in_alu_result = '0;
        bus.in_read_data  = '0;
        bus.in_rd         = '0;
        bus.out_ready     = 1'b0;

        repeat (2) begin
            @(negedge clock);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_in_ready", 64'(bus.in_ready), 64'd0);
            check("rst_ctrl", 64'(bus.out_ctrl), 64'd0);
            check("rst_alu", bus.out_alu_result, 64'd0);
            check("rst_read", bus.out_read_data, 64'd0);
            check("rst_wb", bus.out_wb_data, 64'd0);
            check("rst_rd", 64'(bus.out_rd), 64'd0);
        end
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rel_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("rel_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clock);
        check("rel_in_ready_high", 64'(bus.in_ready), 64'd1);

        tick();
        bus.out_ready = 1'b1;
        push(2'b01, 64'h10, 64'h0, 5'd5, 2'b01, 64'h10);
        push(2'b11, 64'h0, 64'h20, 5'd6, 2'b11, 64'h20);
        @(negedge clock);
        check("stream_no_bubble", 64'(bus.out_valid), 64'd1);
        check("stream_wb2", bus.out_wb_data, 64'h20);
        tick();
        @(negedge clock);
        check("stream_drained", 64'(bus.out_valid), 64'd0);
        check("stream_pops", 64'(pops), 64'd2);

        tick();
        bus.out_ready = 1'b0;
        push(2'b01, 64'h33, 64'h44, 5'd7, 2'b01, 64'h33);
        push(2'b11, 64'h55, 64'h66, 5'd8, 2'b11, 64'h66);
        @(negedge clock);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_rd_a", 64'(bus.out_rd), 64'd7);
        check("bp_wb_a", bus.out_wb_data, 64'h33);
        @(negedge clock);
        check("bp_hold_rd", 64'(bus.out_rd), 64'd7);
        check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        tick();
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("bp_drain_a_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clock);
        check("bp_rd_b", 64'(bus.out_rd), 64'd8);
        check("bp_in_ready_high", 64'(bus.in_ready), 64'd1);
        tick();
        bus.out_ready = 1'b0;

        bus.out_ready = 1'b1;
        push(2'b01, 64'hDEAD, 64'h1234, 5'd0, 2'b00, 64'hDEAD);
        @(negedge clock);
        check("x0_ctrl", 64'(bus.out_ctrl), 64'd0);
        check("x0_wb", bus.out_wb_data, 64'hDEAD);
        tick();
        bus.out_ready = 1'b0;

        push(2'b01, 64'h77, 64'h0, 5'd9, 2'b01, 64'h77);
        push(2'b01, 64'h88, 64'h0, 5'd10, 2'b01, 64'h88);
        flush             = 1'b1;
        bus.in_valid      = 1'b1;
        bus.in_ctrl       = 2'b01;
        bus.in_alu_result = 64'h99;
        bus.in_rd         = 5'd11;
        exp_q.delete();
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("flush2_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush2_ctrl", 64'(bus.out_ctrl), 64'd0);
        check("flush2_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush2_rd_hold", 64'(bus.out_rd), 64'd9);
        check("flush2_wb_hold", bus.out_wb_data, 64'h77);
        tick();
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("flush2_no_ghost", 64'(bus.out_valid), 64'd0);
        end

        tick();
        bus.out_ready = 1'b0;
        push(2'b01, 64'h5, 64'h0, 5'd12, 2'b01, 64'h5);
        flush             = 1'b1;
        bus.in_valid      = 1'b1;
        bus.in_ctrl       = 2'b01;
        bus.in_alu_result = 64'hAB;
        bus.in_rd         = 5'd13;
        exp_q.delete();
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("flush1_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush1_rd_hold", 64'(bus.out_rd), 64'd12);
        tick();
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("flush1_no_ghost", 64'(bus.out_valid), 64'd0);
        end

`ifdef MEMWB_PIPE_STAGE_PERF_EN
        tick();
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        push(2'b01, 64'h42, 64'h0, 5'd3, 2'b01, 64'h42);
        repeat (3) @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("perf_stall", stall_cnt, 64'd3);
        check("perf_bubble_ge2", 64'(bubble_cnt >= 32'd2), 64'd1);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
